// File: rtl/simd_pkg.sv
// simd_pkg: lane-width encodings, FSM states and saturation limits for simd_acc
package simd_pkg;
  localparam logic [1:0] W8 = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;
  localparam logic [7:0] S8_MAX = 8'h7F;
  localparam logic [7:0] S8_MIN = 8'h80;
  localparam logic [15:0] S16_MAX = 16'h7FFF;
  localparam logic [15:0] S16_MIN = 16'h8000;
  localparam logic [31:0] S32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] S32_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
endpackage

// File: rtl/simd_lane_add.sv
// simd_lane_add: packed lane add with carry breaks, per-lane signed overflow and saturation
module simd_lane_add
  import simd_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  width,
  input  logic        sat,
  output logic [31:0] sum,
  output logic [3:0]  ovf
);
  logic w8, w32;
  logic [8:0] s0, s1, s2;
  logic [7:0] s3;
  logic [31:0] raw, lim;
  logic [3:0] bo, lane_ov;
  assign w8 = width == W8;
  assign w32 = !w8 && width != W16;
  // carries only cross byte boundaries that sit inside a lane
  assign s0 = {1'b0, a[7:0]} + {1'b0, b[7:0]};
  assign s1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'(!w8 && s0[8]);
  assign s2 = {1'b0, a[23:16]} + {1'b0, b[23:16]} + 9'(w32 && s1[8]);
  assign s3 = a[31:24] + b[31:24] + 8'(!w8 && s2[8]);
  assign raw = {s3, s2[7:0], s1[7:0], s0[7:0]};
  assign lane_ov = w8 ? bo : w32 ? {4{bo[3]}} : {{2{bo[3]}}, {2{bo[1]}}};
  assign lim = w8 ? {a[31] ? S8_MIN : S8_MAX, a[23] ? S8_MIN : S8_MAX,
                     a[15] ? S8_MIN : S8_MAX, a[7] ? S8_MIN : S8_MAX}
             : w32 ? (a[31] ? S32_MIN : S32_MAX)
             : {a[31] ? S16_MIN : S16_MAX, a[15] ? S16_MIN : S16_MAX};
  assign ovf = w8 ? bo : w32 ? {3'b000, bo[3]} : {1'b0, bo[3], 1'b0, bo[1]};
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign bo[i] = (a[8*i+7] == b[8*i+7]) && (raw[8*i+7] != a[8*i+7]);
    assign sum[8*i+:8] = sat && lane_ov[i] ? lim[8*i+:8] : raw[8*i+:8];
  end
endmodule

// File: rtl/simd_acc.sv
// simd_acc: per-packet SIMD accumulator with lane modes, optional saturation and sticky overflow
module simd_acc
  import simd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  width,
  input  logic        saturate,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_count,
  output logic [3:0]  out_ovf
);
  state_t state, state_nx;
  logic [31:0] acc, sum;
  logic [7:0] count;
  logic [3:0] ovf, lane_ovf;
  logic [1:0] mode;
  logic sat_mode, accept;
  assign accept = in_valid && in_ready;
  simd_lane_add u_add (
    .a(acc), .b(in_data), .width(mode), .sat(sat_mode), .sum(sum), .ovf(lane_ovf)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = accept ? (in_last ? DONE : ACC) : IDLE;
      ACC: state_nx = accept && in_last ? DONE : ACC;
      default: state_nx = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    in_ready = state != DONE;
    out_valid = state == DONE;
  end
  // first beat of a packet reloads everything and freezes the lane mode
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      count <= '0;
      ovf <= '0;
      mode <= W8;
      sat_mode <= 1'b0;
    end else if (accept && state == IDLE) begin
      acc <= in_data;
      count <= 8'd1;
      ovf <= '0;
      mode <= width;
      sat_mode <= saturate;
    end else if (accept) begin
      acc <= sum;
      count <= count + 8'(count != 8'hFF);
      ovf <= ovf | lane_ovf;
    end
  assign out_data = acc;
  assign out_count = count;
  assign out_ovf = ovf;
endmodule

// File: tb/tb_simd_acc.sv
// tb_simd_acc: directed scoreboard bench for simd_acc
module tb_simd_acc;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, saturate = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [1:0] width = 2'b00;
  logic in_ready, out_valid;
  logic [31:0] out_data;
  logic [7:0] out_count;
  logic [3:0] out_ovf;
  int errors = 0, checks = 0;
  typedef struct {logic [31:0] d; logic [7:0] c; logic [3:0] o;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  simd_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .width(width), .saturate(saturate), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] w, input logic s);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; width = w; saturate = s;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] c, input logic [3:0] o);
    exp_t e;
    e.d = d; e.c = c; e.o = o;
    sb.push_back(e);
  endtask

  task automatic get_result(input string tag);
    int n = 0;
    exp_t e;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, out_data, e.d);
      chk({tag, "_count"}, 32'(out_count), 32'(e.c));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(e.o));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    push(32'h7F7F7F7F, 8'd2, 4'hF);
    send(32'h7F7F7F7F, 1'b0, 2'b00, 1'b1);
    send(32'h01010101, 1'b1, 2'b00, 1'b1);
    get_result("w8_sat");

    push(32'h80808080, 8'd2, 4'hF);
    send(32'h7F7F7F7F, 1'b0, 2'b00, 1'b0);
    send(32'h01010101, 1'b1, 2'b00, 1'b0);
    get_result("w8_wrap");

    push(32'h80000003, 8'd2, 4'h4);
    send(32'h80000001, 1'b0, 2'b01, 1'b1);
    send(32'hFFFF0002, 1'b1, 2'b01, 1'b1);
    get_result("w16_sat");

    push(32'h80008000, 8'd2, 4'h5);
    send(32'h7FFF0001, 1'b0, 2'b01, 1'b0);
    send(32'h00017FFF, 1'b1, 2'b01, 1'b0);
    get_result("w16_wrap");

    push(32'h7FFFFFFF, 8'd2, 4'h1);
    send(32'h7FFFFFFF, 1'b0, 2'b11, 1'b1);
    send(32'h00000001, 1'b1, 2'b11, 1'b1);
    get_result("w32_sat");

    // mode change on the second beat must not take effect
    push(32'h00000000, 8'd2, 4'h0);
    send(32'h000000FF, 1'b0, 2'b00, 1'b0);
    send(32'h00000001, 1'b1, 2'b10, 1'b1);
    get_result("mode_latch");

    push(32'h12345678, 8'd1, 4'h0);
    send(32'h12345678, 1'b1, 2'b10, 1'b0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_data", out_data, 32'h12345678);
      chk("hold_count", 32'(out_count), 32'd1);
    end
    get_result("single");

    push(32'h0000012C, 8'd255, 4'h0);
    for (int i = 0; i < 300; i++) send(32'h00000001, i == 299, 2'b10, 1'b0);
    get_result("count_sat");

    for (int i = 0; i < 3; i++) send(32'h00000009, 1'b0, 2'b10, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_data", out_data, 32'd0);
    push(32'h00000005, 8'd1, 4'h0);
    send(32'h00000005, 1'b1, 2'b10, 1'b0);
    get_result("after_rst");

    send(32'h00000033, 1'b1, 2'b10, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("donerst_valid", 32'(out_valid), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/simd_acc.md
SIMD_ACC -- requirements
Module: simd_acc

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, in_data beat valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-005 SHALL have port in_data, input, 32, packed lane vector (adder output format).
REQ-006 SHALL have port in_last, input, 1, final beat of packet.
REQ-007 SHALL have port width, input, 2, lane mode: 00 = 4x8, 01 = 2x16, 10/11 = 1x32.
REQ-008 SHALL have port saturate, input, 1, 1 = signed saturating accumulate, 0 = wrapping.
REQ-009 SHALL have port out_valid, output, 1, packet result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out_data, output, 32, packed per-lane accumulated sum.
REQ-012 SHALL have port out_count, output, 8, beats in packet, saturating at 255.
REQ-013 SHALL have port out_ovf, output, 4, sticky per-lane signed overflow; lane n = byte n; 16-bit lanes report in bits 0/2, 32-bit in bit 0; other bits 0.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACC, 0 in DONE.
REQ-016 SHALL drive out_valid = 1 only in DONE.
REQ-017 Beat accepted iff in_valid && in_ready at a rising edge.
REQ-018 IDLE accept: acc <= in_data, count <= 1, ovf <= 0, latch width and saturate; next ACC, or DONE if in_last.
REQ-019 ACC accept: acc <= acc + in_data per lane under latched mode, count <= min(count+1, 255), ovf |= per-lane overflow; next DONE if in_last, else stay ACC.
REQ-020 Lane add SHALL break carries at lane boundaries; signed overflow = operands same sign, sum sign differs.
REQ-021 On overflow with saturate = 1, lane result SHALL be 0x7F/0x7FFF/0x7FFFFFFF (positive) or 0x80/0x8000/0x80000000 (negative); with saturate = 0 it wraps.
REQ-022 width/saturate changes after first beat of a packet SHALL be ignored until next packet.
REQ-023 out_data, out_count and out_ovf SHALL hold stable throughout DONE.
REQ-024 DONE with out_ready = 1 SHALL return to IDLE next cycle; otherwise stay DONE (backpressure, no input accepted).
REQ-025 Latency: out_valid asserts on the cycle after the in_last beat is accepted.
REQ-026 No cycles without accepted beats SHALL alter acc, count or ovf.

Reset
REQ-027 On rst_n = 0 state SHALL be IDLE; acc, out_data = 0; out_count = 0; out_ovf = 0; out_valid = 0; latched mode = 00, saturate = 0.
REQ-028 Reset asserted mid-packet or in DONE SHALL discard the partial/pending result; no output after release without new beats.
REQ-029 First beat may be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package simd_pkg SHALL hold width encodings (W8, W16, W32), FSM state enum, and saturation limit constants.
REQ-031 Combinational sub-module simd_lane_add SHALL compute packed sum, per-lane overflow, and saturation; instantiated once in simd_acc.

Verification
REQ-032 width=00, sat=1, beats 0x7F7F7F7F then 0x01010101 (last) -> out_data 0x7F7F7F7F, out_ovf 0xF, out_count 2.
REQ-033 width=00, sat=0, same beats -> out_data 0x80808080, out_ovf 0xF.
REQ-034 width=01, sat=1, beats 0x80000001, 0xFFFF0002 (last) -> out_data 0x80000003, out_ovf 0x4.
REQ-035 width=10, single beat 0x12345678 with in_last -> out_valid next cycle, out_data 0x12345678, count 1; hold out_ready=0 5 cycles -> outputs stable, in_ready=0.
REQ-036 300 beats of 0x00000001, width=10, sat=0 -> out_data 0x0000012C, out_count 255.
REQ-037 rst_n pulsed low after 3 beats, then 1 beat 0x00000005 last -> out_data 0x00000005, count 1.
